// File: rtl/comptest_triad_pkg.sv
// Shared definitions for the triad encoder: FSM states, triad geometry and
// the guard-gap length rule.
package comptest_triad_pkg;

   typedef enum logic [2:0] {IDLE, START, STRIP, HALF, GAP} triad_state_e;

   localparam int TRIAD_LEN    = 3;
   localparam int HS_PER_TRIAD = 4;
   localparam int GAP_W        = 5;

   // Gap must cover the decoder persistence, never shorter than min_gap.
   function automatic logic [GAP_W-1:0] gap_load(input logic [3:0]       persist,
                                                 input logic             persist1,
                                                 input logic [GAP_W-1:0] min_gap);
      logic [GAP_W-1:0] need;
      need = persist1 ? GAP_W'(1) : ({1'b0, persist} + GAP_W'(1));
      return (need > min_gap) ? need : min_gap;
   endfunction

endpackage

// File: rtl/triad_req_fifo.sv
// Small synchronous request FIFO holding 2-bit halfstrip indices in front of
// the triad encoder FSM.
module triad_req_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       _reset,
   input  logic       push,
   input  logic [1:0] push_data,
   input  logic       pop,
   output logic [1:0] pop_data,
   output logic       full,
   output logic       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]    mem_q [DEPTH];
   logic [1:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && !full;
      do_pop   = pop && !empty;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/triad_encoder.sv
// Serialises halfstrip requests as start/strip/half triads on one distrip line.
// Define TRIAD_ENCODER_FIFO_EN to queue requests in a FIFO_DEPTH-entry FIFO.
module triad_encoder
   import comptest_triad_pkg::*;
#(
   parameter int MIN_GAP    = 1,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             _reset,
   input  logic             hs_valid,
   input  logic [1:0]       hs_index,
   output logic             ready,
   input  logic [3:0]       persist,
   input  logic             persist1,
   output logic             distrip,
   output logic             busy,
   output logic [CNT_W-1:0] sent_cnt
);

   localparam logic [GAP_W-1:0] MIN_GAP_L = GAP_W'(MIN_GAP);

   triad_state_e     state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             distrip_q, distrip_d;
   logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;

   logic             req_valid;
   logic [1:0]       req_index;
   logic             req_take;

   assign req_take = (state_q == IDLE) && req_valid;

`ifdef TRIAD_ENCODER_FIFO_EN
   logic fifo_full, fifo_empty;

   assign ready     = !fifo_full && _reset;
   assign req_valid = !fifo_empty;

   triad_req_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_req_fifo (
      .clk       (clk),
      ._reset    (_reset),
      .push      (hs_valid && ready),
      .push_data (hs_index),
      .pop       (req_take),
      .pop_data  (req_index),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
`else
   // Requests arriving while busy are dropped, not queued.
   assign ready     = (state_q == IDLE) && _reset;
   assign req_valid = hs_valid && ready;
   assign req_index = hs_index;
`endif

   assign distrip  = distrip_q;
   assign busy     = (state_q != IDLE);
   assign sent_cnt = sent_cnt_q;

   // distrip_d is the bit belonging to the state being entered.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      distrip_d  = 1'b0;
      sent_cnt_d = sent_cnt_q;
      case (state_q)
         IDLE: begin
            if (req_take) begin
               idx_d     = req_index;
               state_d   = START;
               distrip_d = 1'b1;
            end
         end
         START: begin
            state_d   = STRIP;
            distrip_d = idx_q[1];
         end
         STRIP: begin
            state_d   = HALF;
            distrip_d = idx_q[0];
         end
         HALF: begin
            state_d = GAP;
            gap_d   = gap_load(persist, persist1, MIN_GAP_L);
         end
         GAP: begin
            if (gap_q <= GAP_W'(1)) begin
               state_d = IDLE;
               if (sent_cnt_q != '1) begin
                  sent_cnt_d = sent_cnt_q + CNT_W'(1);
               end
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!_reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         gap_q      <= '0;
         distrip_q  <= 1'b0;
         sent_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         gap_q      <= gap_d;
         distrip_q  <= distrip_d;
         sent_cnt_q <= sent_cnt_d;
      end
   end

endmodule
